// File: rtl/vot3_session.sv
// Session controller upstream of the vot3 majority voter: opens a session on start,
// records each voter's first vote, then publishes vot3's majority as a registered result.
module vot3_session #(
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned CNT_W       = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] vote_en,
  input  logic [2:0] vote_val,
  output logic       v1,
  output logic       v2,
  output logic       v3,
  input  logic       vot_in,
  output logic [2:0] voted,
  output logic       busy,
  output logic       result,
  output logic       timeout,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, COLLECT, EVAL} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       v_q, v_d;
  logic [2:0]       voted_q, voted_d;
  logic             busy_q, busy_d;
  logic             result_q, result_d;
  logic             timeout_q, timeout_d;
  logic             tmo_next_q, tmo_next_d;
  logic             done_q, done_d;
  logic [2:0]       new_votes;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    v_d        = v_q;
    voted_d    = voted_q;
    busy_d     = busy_q;
    result_d   = result_q;
    timeout_d  = timeout_q;
    tmo_next_d = tmo_next_q;
    done_d     = 1'b0;
    new_votes  = vote_en & ~voted_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COLLECT;
          cnt_d   = '0;
          v_d     = '0;
          voted_d = '0;
          busy_d  = 1'b1;
        end
      end
      COLLECT: begin
        cnt_d   = cnt_q + CNT_W'(1);
        v_d     = (v_q & ~new_votes) | (vote_val & new_votes);
        voted_d = voted_q | vote_en;
        // A final vote landing on the timeout cycle wins over the timeout.
        if (&voted_d) begin
          state_d    = EVAL;
          tmo_next_d = 1'b0;
        end else if (cnt_q == LAST_CNT) begin
          state_d    = EVAL;
          tmo_next_d = 1'b1;
        end
      end
      EVAL: begin
        result_d  = vot_in;
        timeout_d = tmo_next_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      v_q        <= '0;
      voted_q    <= '0;
      busy_q     <= 1'b0;
      result_q   <= 1'b0;
      timeout_q  <= 1'b0;
      tmo_next_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      v_q        <= v_d;
      voted_q    <= voted_d;
      busy_q     <= busy_d;
      result_q   <= result_d;
      timeout_q  <= timeout_d;
      tmo_next_q <= tmo_next_d;
      done_q     <= done_d;
    end
  end

  assign v1      = v_q[0];
  assign v2      = v_q[1];
  assign v3      = v_q[2];
  assign voted   = voted_q;
  assign busy    = busy_q;
  assign result  = result_q;
  assign timeout = timeout_q;
  assign done    = done_q;

endmodule

// File: tb/tb_vot3_session.sv
// Bench for vot3_session: per-session schedules of first votes are turned into
// expected outcome, timing and latched votes, with vot3 modelled beside the DUT.
module tb_vot3_session;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] vote_en;
  logic [2:0] vote_val;
  logic       v1, v2, v3;
  logic       vot_in;
  logic [2:0] voted;
  logic       busy, result, timeout, done;

  int checks = 0;
  int errors = 0;

  vot3_session #(.TIMEOUT_CYC(T), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vote_en(vote_en), .vote_val(vote_val),
    .v1(v1), .v2(v2), .v3(v3), .vot_in(vot_in), .voted(voted), .busy(busy),
    .result(result), .timeout(timeout), .done(done)
  );

  // Downstream vot3 majority voter.
  assign vot_in = (v1 & v2) | (v1 & v3) | (v2 & v3);

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_v"}, {29'd0, v3, v2, v1}, 32'd0);
    check_eq({tag, "_voted"}, {29'd0, voted}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_result"}, {31'd0, result}, 32'd0);
    check_eq({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  // f[i]: COLLECT cycle index (0 = first cycle after start) of voter i's first vote;
  // f[i] >= T means the voter abstains. Later votes by the same voter carry the
  // opposite value and must be ignored.
  task automatic run_session(input int f0, input int f1, input int f2,
                             input logic [2:0] vals, input int n_idle);
    int f[3];
    int m, end_idx, yes;
    bit tmo;
    logic [2:0] rec, exp_v;
    f = '{f0, f1, f2};
    m = f0;
    if (f1 > m) m = f1;
    if (f2 > m) m = f2;
    if (m <= T - 1) begin
      end_idx = m;
      tmo = 1'b0;
    end else begin
      end_idx = T - 1;
      tmo = 1'b1;
    end
    yes = 0;
    for (int i = 0; i < 3; i++) begin
      rec[i] = (f[i] <= end_idx);
      exp_v[i] = rec[i] & vals[i];
      if (exp_v[i]) yes++;
    end

    start = 1'b1;
    vote_en = 3'($urandom);
    vote_val = 3'($urandom);
    tick();
    start = 1'b0;
    check_eq("open_busy", {31'd0, busy}, 32'd1);
    check_eq("open_voted", {29'd0, voted}, 32'd0);
    check_eq("open_done", {31'd0, done}, 32'd0);

    for (int c = 0; c <= end_idx + 1; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (c == f[i]) begin
          vote_en[i] = 1'b1;
          vote_val[i] = vals[i];
        end else if (c > f[i]) begin
          vote_en[i] = 1'($urandom);
          vote_val[i] = ~vals[i];
        end else begin
          vote_en[i] = 1'b0;
          vote_val[i] = 1'($urandom);
        end
      end
      start = 1'($urandom);
      tick();
      check_eq("busy", {31'd0, busy}, {31'd0, c <= end_idx});
      check_eq("done", {31'd0, done}, {31'd0, c == end_idx + 1});
    end
    start = 1'b0;
    vote_en = '0;

    check_eq("result", {31'd0, result}, {31'd0, yes >= 2});
    check_eq("timeout", {31'd0, timeout}, {31'd0, tmo});
    check_eq("voted", {29'd0, voted}, {29'd0, rec});
    check_eq("v", {29'd0, v3, v2, v1}, {29'd0, exp_v});

    for (int k = 0; k < n_idle; k++) begin
      vote_en = 3'($urandom);
      vote_val = 3'($urandom);
      tick();
      check_eq("idle_done", {31'd0, done}, 32'd0);
      check_eq("idle_voted", {29'd0, voted}, {29'd0, rec});
      check_eq("idle_result", {31'd0, result}, {31'd0, yes >= 2});
    end
    vote_en = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    vote_en = '0;
    vote_val = '0;
    tick();
    tick();
    check_idle_zero("reset");
    rst_n = 1'b1;
    vote_en = 3'b111;
    vote_val = 3'b111;
    tick();
    tick();
    check_eq("idle_vote_ignored", {29'd0, voted}, 32'd0);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    vote_en = '0;

    run_session(1, 3, 5, 3'b011, 1);           // staggered votes, result 1
    run_session(0, 0, 0, 3'b100, 0);           // all at once, result 0
    run_session(0, 2, 3, 3'b101, 2);           // duplicates ignored, result 1
    run_session(0, T + 1, T + 1, 3'b001, 1);   // timeout, result 0
    run_session(0, 1, T + 1, 3'b011, 0);       // timeout, result 1
    run_session(0, 1, T - 1, 3'b110, 1);       // final vote on timeout cycle
    run_session(0, 1, T, 3'b111, 1);           // vote one cycle too late

    // Reset mid-COLLECT discards the session without a done pulse.
    start = 1'b1;
    tick();
    start = 1'b0;
    vote_en = 3'b011;
    vote_val = 3'b011;
    tick();
    vote_en = '0;
    check_eq("pre_rst_voted", {29'd0, voted}, 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle_zero("mid_rst");
    for (int k = 0; k < T + 3; k++) begin
      tick();
      check_eq("post_rst_done", {31'd0, done}, 32'd0);
    end

    for (int s = 0; s < 40; s++) begin
      run_session(int'($urandom_range(0, T + 1)), int'($urandom_range(0, T + 1)),
                  int'($urandom_range(0, T + 1)), 3'($urandom),
                  int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
